// File: rtl/run_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : run_ctrl_pkg
// Description : Shared types for the CPU run controller. This package holds
//               the FSM state encoding, the halt-cause encoding and a helper
//               that sizes the breakpoint index.
// Revision    : 1.0 - initial release
// ============================================================================
package run_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_RESET     = 3'd1,
        ST_RUN       = 3'd2,
        ST_STEP_WAIT = 3'd3,
        ST_HALTED    = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_EBREAK  = 2'd1,
        CAUSE_BP      = 2'd2,
        CAUSE_TIMEOUT = 2'd3
    } cause_e;

    // A single comparator still needs a 1-bit index port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/run_ctrl_bp_match.sv
`default_nettype none
// ============================================================================
// Module      : run_ctrl_bp_match
// Description : This block holds NUM_BP PC breakpoint comparators and a
//               lowest-index priority encoder. It is purely combinational.
// Ports       : pc_i      - current core PC
//               bp_en_i   - per-comparator enable
//               bp_addr_i - packed breakpoint addresses, entry i at [i*PC_W +: PC_W]
//               hit_o     - at least one enabled comparator matches
//               idx_o     - lowest matching comparator index (0 when no hit)
// Revision    : 1.0 - initial release
// ============================================================================
module run_ctrl_bp_match
    import run_ctrl_pkg::*;
#(
    parameter int PC_W   = 32,
    parameter int NUM_BP = 2,
    parameter int IDX_W  = idx_width(NUM_BP)
) (
    input  logic [PC_W-1:0]        pc_i,
    input  logic [NUM_BP-1:0]      bp_en_i,
    input  logic [NUM_BP*PC_W-1:0] bp_addr_i,
    output logic                   hit_o,
    output logic [IDX_W-1:0]       idx_o
);

    logic [NUM_BP-1:0] w_match;

    for (genvar g = 0; g < NUM_BP; g++) begin : g_cmp
        assign w_match[g] = bp_en_i[g] && (pc_i == bp_addr_i[g*PC_W +: PC_W]);
    end

    // The loop scans downward so that the lowest matching index is written last.
    always_comb begin
        hit_o = |w_match;
        idx_o = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cpu_run_ctrl
// Description : This is the run sequencer for the single-cycle RV core.
//               It holds the core in reset for RESET_CYCLES and then lets it
//               run. It stops the core on ebreak, on a PC breakpoint or on a
//               cycle timeout, and it reports the cause and the cycle count.
//               Single-step support is built only when RUN_CTRL_STEP_EN is
//               defined.
// Ports       : clk/rst          - clock, synchronous active-high reset
//               start/resume     - sequence start / breakpoint resume pulses
//               step_mode/step_req - single-step select / step pulse
//               ebreak_i, pc_i   - core status
//               bp_en, bp_addr   - breakpoint configuration
//               cpu_rst_o, cpu_halt_o - core control (registered)
//               state_o, cycle_cnt_o, done_o, timeout_o, bp_hit_o, bp_idx_o
//                                - status (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int RESET_CYCLES = 3,
    parameter int MAX_CYCLES   = 500000,
    parameter int CNT_W        = 32,
    parameter int PC_W         = 32,
    parameter int NUM_BP       = 2,
    parameter int IDX_W        = idx_width(NUM_BP)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   resume,
    input  logic                   step_mode,
    input  logic                   step_req,
    input  logic                   ebreak_i,
    input  logic [PC_W-1:0]        pc_i,
    input  logic [NUM_BP-1:0]      bp_en,
    input  logic [NUM_BP*PC_W-1:0] bp_addr,
    output logic                   cpu_rst_o,
    output logic                   cpu_halt_o,
    output logic [STATE_W-1:0]     state_o,
    output logic [CNT_W-1:0]       cycle_cnt_o,
    output logic                   done_o,
    output logic                   timeout_o,
    output logic                   bp_hit_o,
    output logic [IDX_W-1:0]       bp_idx_o
);

    localparam int              RC_W       = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RC_W-1:0] RESET_LOAD = RC_W'(RESET_CYCLES - 1);
    localparam bit              TO_EN      = (MAX_CYCLES != 0);
    localparam logic [CNT_W-1:0] TIMEOUT_AT = CNT_W'(MAX_CYCLES - 1);

    state_e            state_q, state_d;
    logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic              bp_hit_q, bp_hit_d;
    logic [IDX_W-1:0]  bp_idx_q, bp_idx_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              cpu_halt_q, cpu_halt_d;
    logic              bp_mask_q, bp_mask_d;
`ifdef RUN_CTRL_STEP_EN
    logic              step_q, step_d;
`else
    logic              w_unused_step;
    assign w_unused_step = step_mode ^ step_req;
`endif

    logic              w_bp_hit;
    logic [IDX_W-1:0]  w_bp_idx;
    cause_e            w_cause;
    logic              w_active;

    run_ctrl_bp_match #(
        .PC_W   (PC_W),
        .NUM_BP (NUM_BP),
        .IDX_W  (IDX_W)
    ) u_bp_match (
        .pc_i      (pc_i),
        .bp_en_i   (bp_en),
        .bp_addr_i (bp_addr),
        .hit_o     (w_bp_hit),
        .idx_o     (w_bp_idx)
    );

    // Stop-cause priority is ebreak, then breakpoint, then timeout. The
    // breakpoint is masked on the first cycle after a resume so that the
    // same PC does not trigger again right away.
    always_comb begin
        w_cause = CAUSE_NONE;
        if (ebreak_i) begin
            w_cause = CAUSE_EBREAK;
        end else if (w_bp_hit && !bp_mask_q) begin
            w_cause = CAUSE_BP;
        end else if (TO_EN && (cnt_q == TIMEOUT_AT)) begin
            w_cause = CAUSE_TIMEOUT;
        end
    end

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        bp_hit_d  = bp_hit_q;
        bp_idx_d  = bp_idx_q;
        bp_mask_d = 1'b0;
        w_active  = 1'b0;
`ifdef RUN_CTRL_STEP_EN
        step_d    = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_RESET;
                    rst_cnt_d = RESET_LOAD;
                    cnt_d     = '0;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                    bp_hit_d  = 1'b0;
                    bp_idx_d  = '0;
                end
            end
            ST_RESET: begin
                if (rst_cnt_q == '0) begin
`ifdef RUN_CTRL_STEP_EN
                    state_d = step_mode ? ST_STEP_WAIT : ST_RUN;
`else
                    state_d = ST_RUN;
`endif
                end else begin
                    rst_cnt_d = rst_cnt_q - RC_W'(1);
                end
            end
            ST_RUN: begin
                w_active = 1'b1;
            end
`ifdef RUN_CTRL_STEP_EN
            ST_STEP_WAIT: begin
                // While a step is in progress, any further step_req is ignored.
                if (step_q) begin
                    w_active = 1'b1;
                end else if (step_req) begin
                    step_d = 1'b1;
                end
            end
`endif
            ST_HALTED: begin
                if (start) begin
                    state_d   = ST_RESET;
                    rst_cnt_d = RESET_LOAD;
                    cnt_d     = '0;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                    bp_hit_d  = 1'b0;
                    bp_idx_d  = '0;
                end else if (resume && bp_hit_q) begin
                    state_d   = ST_RUN;
                    bp_hit_d  = 1'b0;
                    bp_mask_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The core executed this cycle. Count it and evaluate the stop
        // conditions.
        if (w_active) begin
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
            if (w_cause != CAUSE_NONE) begin
                state_d = ST_HALTED;
`ifdef RUN_CTRL_STEP_EN
                step_d  = 1'b0;
`endif
            end
            case (w_cause)
                CAUSE_EBREAK:  done_d    = 1'b1;
                CAUSE_TIMEOUT: timeout_d = 1'b1;
                CAUSE_BP: begin
                    bp_hit_d = 1'b1;
                    bp_idx_d = w_bp_idx;
                end
                default: ;
            endcase
        end

        // The core control outputs are registered versions of the next state.
        cpu_rst_d  = (state_d == ST_IDLE) || (state_d == ST_RESET);
        cpu_halt_d = !((state_d == ST_RUN) || (state_d == ST_RESET));
`ifdef RUN_CTRL_STEP_EN
        if (step_d) begin
            cpu_halt_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rst_cnt_q  <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            bp_hit_q   <= 1'b0;
            bp_idx_q   <= '0;
            cpu_rst_q  <= 1'b1;
            cpu_halt_q <= 1'b1;
            bp_mask_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_cnt_q  <= rst_cnt_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            bp_hit_q   <= bp_hit_d;
            bp_idx_q   <= bp_idx_d;
            cpu_rst_q  <= cpu_rst_d;
            cpu_halt_q <= cpu_halt_d;
            bp_mask_q  <= bp_mask_d;
        end
    end

`ifdef RUN_CTRL_STEP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step_d;
        end
    end
`endif

    assign cpu_rst_o   = cpu_rst_q;
    assign cpu_halt_o  = cpu_halt_q;
    assign state_o     = state_q;
    assign cycle_cnt_o = cnt_q;
    assign done_o      = done_q;
    assign timeout_o   = timeout_q;
    assign bp_hit_o    = bp_hit_q;
    assign bp_idx_o    = bp_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_run_ctrl
// Description : Directed self-checking bench for cpu_run_ctrl with
//               RESET_CYCLES=3, MAX_CYCLES=10 and two breakpoints.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_run_ctrl;

    localparam int PC_W   = 32;
    localparam int NUM_BP = 2;
    localparam int CNT_W  = 32;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic                   resume;
    logic                   step_mode;
    logic                   step_req;
    logic                   ebreak_i;
    logic [PC_W-1:0]        pc_i;
    logic [NUM_BP-1:0]      bp_en;
    logic [NUM_BP*PC_W-1:0] bp_addr;
    logic                   cpu_rst_o;
    logic                   cpu_halt_o;
    logic [2:0]             state_o;
    logic [CNT_W-1:0]       cycle_cnt_o;
    logic                   done_o;
    logic                   timeout_o;
    logic                   bp_hit_o;
    logic [0:0]             bp_idx_o;

    int n_checks = 0;
    int n_errors = 0;

    cpu_run_ctrl #(
        .RESET_CYCLES (3),
        .MAX_CYCLES   (10),
        .CNT_W        (CNT_W),
        .PC_W         (PC_W),
        .NUM_BP       (NUM_BP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .resume      (resume),
        .step_mode   (step_mode),
        .step_req    (step_req),
        .ebreak_i    (ebreak_i),
        .pc_i        (pc_i),
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .cpu_rst_o   (cpu_rst_o),
        .cpu_halt_o  (cpu_halt_o),
        .state_o     (state_o),
        .cycle_cnt_o (cycle_cnt_o),
        .done_o      (done_o),
        .timeout_o   (timeout_o),
        .bp_hit_o    (bp_hit_o),
        .bp_idx_o    (bp_idx_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; resume = 1'b0; step_mode = 1'b0; step_req = 1'b0;
        ebreak_i = 1'b0; pc_i = '0; bp_en = '0; bp_addr = '0;

        // Reset state
        tick(); tick();
        rst = 1'b0;
        chk("rst_state", 32'(state_o), 0);
        chk("rst_cpu_rst", 32'(cpu_rst_o), 1);
        chk("rst_cpu_halt", 32'(cpu_halt_o), 1);
        chk("rst_cnt", cycle_cnt_o, 0);
        chk("rst_flags", {29'd0, done_o, timeout_o, bp_hit_o}, 0);
        chk("rst_idx", 32'(bp_idx_o), 0);

        // Inputs other than start are ignored in IDLE
        ebreak_i = 1'b1; resume = 1'b1; step_req = 1'b1;
        tick();
        ebreak_i = 1'b0; resume = 1'b0; step_req = 1'b0;
        tick();
        chk("idle_ignore", 32'(state_o), 0);

        // Start: reset is held for exactly 3 cycles, then RUN
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("reset_state_c1", 32'(state_o), 1);
        chk("reset_cpu_rst_c1", 32'(cpu_rst_o), 1);
        chk("reset_cpu_halt_c1", 32'(cpu_halt_o), 0);
        tick();
        chk("reset_cpu_rst_c2", 32'(cpu_rst_o), 1);
        tick();
        chk("reset_cpu_rst_c3", 32'(cpu_rst_o), 1);
        tick();
        chk("run_state", 32'(state_o), 2);
        chk("run_cpu_rst", 32'(cpu_rst_o), 0);
        chk("run_cpu_halt", 32'(cpu_halt_o), 0);
        chk("run_cnt0", cycle_cnt_o, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("run_cnt1", cycle_cnt_o, 1);
        chk("run_start_ignored", 32'(state_o), 2);
        tick();
        chk("run_cnt2", cycle_cnt_o, 2);

        // Timeout after the 10th run cycle
        repeat (7) tick();
        chk("pre_to_cnt", cycle_cnt_o, 9);
        chk("pre_to_halt", 32'(cpu_halt_o), 0);
        tick();
        chk("to_state", 32'(state_o), 4);
        chk("to_cnt", cycle_cnt_o, 10);
        chk("to_flag", 32'(timeout_o), 1);
        chk("to_halt", 32'(cpu_halt_o), 1);
        chk("to_other_flags", {30'd0, done_o, bp_hit_o}, 0);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        repeat (3) tick();
        chk("to_resume_ignored", 32'(state_o), 4);
        chk("to_cnt_frozen", cycle_cnt_o, 10);

        // Breakpoints: both at 0x40, the lowest index wins
        bp_en = 2'b11;
        bp_addr = {32'h40, 32'h40};
        pc_i = 32'h0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_state", 32'(state_o), 1);
        chk("restart_cnt", cycle_cnt_o, 0);
        chk("restart_to_clr", 32'(timeout_o), 0);
        repeat (3) tick();
        tick(); tick();
        chk("bp_pre_cnt", cycle_cnt_o, 2);
        pc_i = 32'h40;
        tick();
        chk("bp_state", 32'(state_o), 4);
        chk("bp_hit", 32'(bp_hit_o), 1);
        chk("bp_idx0", 32'(bp_idx_o), 0);
        chk("bp_cnt", cycle_cnt_o, 3);
        chk("bp_halt", 32'(cpu_halt_o), 1);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("resume_state", 32'(state_o), 2);
        chk("resume_hit_clr", 32'(bp_hit_o), 0);
        chk("resume_halt", 32'(cpu_halt_o), 0);
        tick();
        chk("resume_masked", 32'(state_o), 2);
        chk("resume_cnt", cycle_cnt_o, 4);
        tick();
        chk("bp_retrigger", 32'(state_o), 4);
        chk("bp_retrigger_cnt", cycle_cnt_o, 5);

        // Only comparator 1 is enabled, so the index is 1
        bp_en = 2'b10;
        bp_addr = {32'h80, 32'h40};
        pc_i = 32'h80;
        resume = 1'b1;
        tick();
        resume = 1'b0;
        tick();
        chk("bp1_masked", 32'(state_o), 2);
        tick();
        chk("bp1_hit", 32'(bp_hit_o), 1);
        chk("bp1_idx", 32'(bp_idx_o), 1);
        chk("bp1_cnt", cycle_cnt_o, 7);

        // ebreak and breakpoint in the same cycle: ebreak wins
        pc_i = 32'h0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart2_flags", {29'd0, done_o, timeout_o, bp_hit_o}, 0);
        chk("restart2_cnt", cycle_cnt_o, 0);
        repeat (3) tick();
        ebreak_i = 1'b1;
        pc_i = 32'h80;
        tick();
        ebreak_i = 1'b0;
        pc_i = 32'h0;
        chk("eb_state", 32'(state_o), 4);
        chk("eb_done", 32'(done_o), 1);
        chk("eb_bp_clear", 32'(bp_hit_o), 0);
        chk("eb_cnt", cycle_cnt_o, 1);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("eb_resume_ignored", 32'(state_o), 4);
        start = 1'b1; resume = 1'b1;
        tick();
        start = 1'b0; resume = 1'b0;
        chk("eb_restart_state", 32'(state_o), 1);
        chk("eb_restart_done", 32'(done_o), 0);
        chk("eb_restart_cnt", cycle_cnt_o, 0);

        // rst mid-run
        repeat (3) tick();
        repeat (7) tick();
        chk("mid_cnt", cycle_cnt_o, 7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_state", 32'(state_o), 0);
        chk("mid_rst_cpu_rst", 32'(cpu_rst_o), 1);
        chk("mid_rst_halt", 32'(cpu_halt_o), 1);
        chk("mid_rst_cnt", cycle_cnt_o, 0);

        // Single step
        step_mode = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
`ifdef RUN_CTRL_STEP_EN
        chk("step_state", 32'(state_o), 3);
        chk("step_halt", 32'(cpu_halt_o), 1);
        for (int i = 0; i < 3; i++) begin
            step_req = 1'b1;
            tick();
            chk("step_low", 32'(cpu_halt_o), 0);
            tick();
            step_req = 1'b0;
            chk("step_high", 32'(cpu_halt_o), 1);
            chk("step_cnt", cycle_cnt_o, 32'(i + 1));
            tick(); tick();
        end
        chk("step_total", cycle_cnt_o, 3);
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        ebreak_i = 1'b1;
        tick();
        ebreak_i = 1'b0;
        chk("step_eb_state", 32'(state_o), 4);
        chk("step_eb_done", 32'(done_o), 1);
        chk("step_eb_cnt", cycle_cnt_o, 4);
`else
        chk("nostep_state", 32'(state_o), 2);
        chk("nostep_halt", 32'(cpu_halt_o), 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
